// File: rtl/single_cycle_cpu.sv
// single_cycle_cpu: single-cycle LEGv8 subset core with instruction ROM, register file, ALU and data RAM
module single_cycle_cpu #(
  parameter int IMEM_WORDS = 64,
  parameter int DMEM_WORDS = 32
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [63:0] startPC,
  output logic [63:0] currentPC,
  output logic [63:0] dMemOut
);
  logic [63:0] pc_q, pc_d, dout_q, dout_d;
  logic [63:0] regs_q [32];
  logic [63:0] regs_d [32];
  logic [63:0] dmem_q [DMEM_WORDS];
  logic [63:0] dmem_d [DMEM_WORDS];
  logic [31:0] instr;
  logic [4:0]  rd, rn, rm, rb_idx, didx;
  logic [63:0] ra, rb, imm, dofs, addr, res, mem_rd, cofs, bofs;
  logic        is_add, is_sub, is_and, is_orr, is_addi, is_subi, is_andi, is_orri;
  logic        is_ldur, is_stur, is_cbz, is_cbnz, is_b, wr_en, taken;
  logic        unused_addr;

  function automatic logic [31:0] rom(input logic [5:0] a);
    case (a)
      6'd0:    rom = {10'b1001000100, 12'd1, 5'd31, 5'd1};
      6'd1:    rom = {10'b1001000100, 12'd0, 5'd31, 5'd2};
      6'd2:    rom = {10'b1001000100, 12'd4, 5'd31, 5'd3};
      6'd3:    rom = {11'b10101010000, 5'd1, 6'd0, 5'd2, 5'd2};
      6'd4:    rom = {11'b10001011000, 5'd1, 6'd0, 5'd1, 5'd1};
      6'd5:    rom = {10'b1101000100, 12'd1, 5'd3, 5'd3};
      6'd6:    rom = {8'b10110101, 19'h7fffd, 5'd3};
      6'd7:    rom = {11'b11111000000, 9'd8, 2'b00, 5'd31, 5'd2};
      6'd8:    rom = {11'b11111000010, 9'd8, 2'b00, 5'd31, 5'd4};
      6'd9:    rom = {11'b10001011000, 5'd31, 6'd0, 5'd4, 5'd5};
      6'd10:   rom = {11'b11111000000, 9'd16, 2'b00, 5'd31, 5'd5};
      6'd11:   rom = {11'b11111000010, 9'd16, 2'b00, 5'd31, 5'd6};
      6'd12:   rom = {6'b000101, 26'd0};
      default: rom = '0;
    endcase
  endfunction

  // fetch, field extraction and opcode decode
  always_comb begin
    instr   = (int'(pc_q[7:2]) < IMEM_WORDS) ? rom(pc_q[7:2]) : '0;
    rd      = instr[4:0];
    rn      = instr[9:5];
    rm      = instr[20:16];
    is_add  = instr[31:21] == 11'b10001011000;
    is_sub  = instr[31:21] == 11'b11001011000;
    is_and  = instr[31:21] == 11'b10001010000;
    is_orr  = instr[31:21] == 11'b10101010000;
    is_addi = instr[31:22] == 10'b1001000100;
    is_subi = instr[31:22] == 10'b1101000100;
    is_andi = instr[31:22] == 10'b1001001000;
    is_orri = instr[31:22] == 10'b1011001000;
    is_ldur = instr[31:21] == 11'b11111000010;
    is_stur = instr[31:21] == 11'b11111000000;
    is_cbz  = instr[31:24] == 8'b10110100;
    is_cbnz = instr[31:24] == 8'b10110101;
    is_b    = instr[31:26] == 6'b000101;
    imm     = {52'b0, instr[21:10]};
    dofs    = {{55{instr[20]}}, instr[20:12]};
    cofs    = {{43{instr[23]}}, instr[23:5], 2'b00};
    bofs    = {{36{instr[25]}}, instr[25:0], 2'b00};
  end

  // register reads, ALU, memory address and branch resolution
  always_comb begin
    rb_idx      = (is_stur | is_cbz | is_cbnz) ? rd : rm;
    ra          = (rn == 5'd31) ? '0 : regs_q[rn];
    rb          = (rb_idx == 5'd31) ? '0 : regs_q[rb_idx];
    addr        = ra + dofs;
    didx        = addr[7:3];
    unused_addr = ^{addr[63:8], addr[2:0]};
    mem_rd      = dmem_q[didx];
    res         = is_add  ? ra + rb :
                  is_sub  ? ra - rb :
                  is_and  ? ra & rb :
                  is_orr  ? ra | rb :
                  is_addi ? ra + imm :
                  is_subi ? ra - imm :
                  is_andi ? ra & imm : ra | imm;
    wr_en       = is_add | is_sub | is_and | is_orr | is_addi | is_subi | is_andi | is_orri | is_ldur;
    taken       = (is_cbz & (rb == '0)) | (is_cbnz & (rb != '0));
  end

  // next architectural state: writeback, store, load capture and next PC
  always_comb begin
    regs_d = regs_q;
    dmem_d = dmem_q;
    if (wr_en && rd != 5'd31) regs_d[rd] = is_ldur ? mem_rd : res;
    if (is_stur) dmem_d[didx] = rb;
    dout_d = is_ldur ? mem_rd : dout_q;
    pc_d   = is_b ? pc_q + bofs : taken ? pc_q + cofs : pc_q + 64'd4;
  end

  // state registers; reset holds the PC at the reset vector and clears all data state
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pc_q   <= startPC;
      dout_q <= '0;
      regs_q <= '{default: '0};
      dmem_q <= '{default: '0};
    end else begin
      pc_q   <= pc_d;
      dout_q <= dout_d;
      regs_q <= regs_d;
      dmem_q <= dmem_d;
    end
  end

  assign currentPC = pc_q;
  assign dMemOut   = dout_q;
endmodule

// File: tb/tb_single_cycle_cpu.sv
// tb_single_cycle_cpu: vector table, corner sequences and random runs against an instruction-level model
module tb_single_cycle_cpu;
  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [63:0] startPC = '0;
  logic [63:0] currentPC, dMemOut;
  int          vectors = 0;
  int          miscompares = 0;

  single_cycle_cpu dut (
    .Clk(Clk), .Reset(Reset), .startPC(startPC),
    .currentPC(currentPC), .dMemOut(dMemOut)
  );

  always #5 Clk = ~Clk;

  typedef enum {OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_ADDI, OP_SUBI, OP_ANDI, OP_ORRI,
                OP_LDUR, OP_STUR, OP_CBZ, OP_CBNZ, OP_B} op_e;
  typedef struct { op_e op; int d; int n; int m; longint imm; } ins_t;
  typedef struct { logic [63:0] spc; int edges; logic [63:0] pc; logic [63:0] dout; } vec_t;

  ins_t        prog [64];
  logic [63:0] mx [32];
  logic [63:0] mm [32];
  logic [63:0] mpc, mdout;

  function automatic logic [63:0] rx(input int r);
    return (r == 31) ? 64'd0 : mx[r];
  endfunction

  task automatic wr(input int r, input logic [63:0] v);
    if (r != 31) mx[r] = v;
  endtask

  task automatic m_reset(input logic [63:0] s);
    foreach (mx[i]) mx[i] = '0;
    foreach (mm[i]) mm[i] = '0;
    mpc = s;
    mdout = '0;
  endtask

  task automatic m_step();
    ins_t        i;
    logic [63:0] ea, nx, iv;
    i  = prog[mpc[7:2]];
    iv = 64'(i.imm);
    nx = mpc + 64'd4;
    ea = rx(i.n) + iv;
    case (i.op)
      OP_ADD:  wr(i.d, rx(i.n) + rx(i.m));
      OP_SUB:  wr(i.d, rx(i.n) - rx(i.m));
      OP_AND:  wr(i.d, rx(i.n) & rx(i.m));
      OP_ORR:  wr(i.d, rx(i.n) | rx(i.m));
      OP_ADDI: wr(i.d, rx(i.n) + iv);
      OP_SUBI: wr(i.d, rx(i.n) - iv);
      OP_ANDI: wr(i.d, rx(i.n) & iv);
      OP_ORRI: wr(i.d, rx(i.n) | iv);
      OP_LDUR: begin mdout = mm[ea[7:3]]; wr(i.d, mdout); end
      OP_STUR: mm[ea[7:3]] = rx(i.d);
      OP_CBZ:  if (rx(i.d) == 0) nx = mpc + iv * 4;
      OP_CBNZ: if (rx(i.d) != 0) nx = mpc + iv * 4;
      OP_B:    nx = mpc + iv * 4;
      default: ;
    endcase
    mpc = nx;
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic apply_reset(input logic [63:0] s, input int hold, input bit chk);
    #2;
    Reset = 1'b1;
    startPC = s;
    m_reset(s);
    #1;
    if (chk) begin
      check("reset_pc", currentPC, s);
      check("reset_dout", dMemOut, 64'd0);
    end
    repeat (hold) @(posedge Clk);
    #1;
    if (chk && hold > 0) begin
      check("reset_hold_pc", currentPC, s);
      check("reset_hold_dout", dMemOut, 64'd0);
    end
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  task automatic tick(input bit chk);
    @(posedge Clk);
    #1;
    m_step();
    if (chk) begin
      check("model_pc", currentPC, mpc);
      check("model_dout", dMemOut, mdout);
    end
  endtask

  initial begin
    vec_t        vt [$];
    logic [63:0] prev, s;
    int          taken, visits, first;
    foreach (prog[i]) prog[i] = '{OP_NOP, 0, 0, 0, 0};
    prog[0]  = '{OP_ADDI, 1, 31, 0, 1};
    prog[1]  = '{OP_ADDI, 2, 31, 0, 0};
    prog[2]  = '{OP_ADDI, 3, 31, 0, 4};
    prog[3]  = '{OP_ORR,  2, 2, 1, 0};
    prog[4]  = '{OP_ADD,  1, 1, 1, 0};
    prog[5]  = '{OP_SUBI, 3, 3, 0, 1};
    prog[6]  = '{OP_CBNZ, 3, 0, 0, -3};
    prog[7]  = '{OP_STUR, 2, 31, 0, 8};
    prog[8]  = '{OP_LDUR, 4, 31, 0, 8};
    prog[9]  = '{OP_ADD,  5, 4, 31, 0};
    prog[10] = '{OP_STUR, 5, 31, 0, 16};
    prog[11] = '{OP_LDUR, 6, 31, 0, 16};
    prog[12] = '{OP_B,    0, 0, 0, 0};

    vt.push_back('{64'h0, 0, 64'h0, 64'h0});
    vt.push_back('{64'h0, 3, 64'h0c, 64'h0});
    vt.push_back('{64'h0, 24, 64'h30, 64'hf});
    vt.push_back('{64'h0, 25, 64'h30, 64'hf});
    vt.push_back('{64'h0, 40, 64'h30, 64'hf});
    vt.push_back('{64'h1c, 2, 64'h24, 64'h0});
    vt.push_back('{64'h0, 30, 64'h30, 64'hf});
    vt.push_back('{64'h2c, 1, 64'h30, 64'h0});
    vt.push_back('{64'h0c, 1, 64'h10, 64'h0});
    vt.push_back('{64'h18, 1, 64'h1c, 64'h0});
    vt.push_back('{64'h40, 1, 64'h44, 64'h0});
    vt.push_back('{64'h40, 5, 64'h54, 64'h0});
    vt.push_back('{64'h30, 3, 64'h30, 64'h0});
    vt.push_back('{64'hfc, 1, 64'h100, 64'h0});
    vt.push_back('{64'h100, 24, 64'h130, 64'hf});
    vt.push_back('{64'hffffffff_fffffffc, 1, 64'h0, 64'h0});
    vt.push_back('{64'h2, 24, 64'h32, 64'hf});

    apply_reset(64'h0, 3, 1'b1);
    foreach (vt[k]) begin
      apply_reset(vt[k].spc, 0, 1'b0);
      repeat (vt[k].edges) tick(1'b0);
      check($sformatf("vec%0d_pc", k), currentPC, vt[k].pc);
      check($sformatf("vec%0d_dout", k), dMemOut, vt[k].dout);
    end

    apply_reset(64'h0, 0, 1'b0);
    taken = 0; visits = 0; first = -1; prev = 64'h0;
    for (int e = 1; e <= 30; e++) begin
      tick(1'b0);
      if (prev == 64'h18 && currentPC == 64'h0c) taken++;
      if (currentPC == 64'h0c) visits++;
      if (currentPC == 64'h30 && first < 0) first = e;
      prev = currentPC;
    end
    check("loop_taken", 64'(taken), 64'd3);
    check("loop_visits", 64'(visits), 64'd4);
    check("first_halt_edge", 64'(first), 64'd24);
    check("pre_reset_dout", dMemOut, 64'hf);
    #2;
    Reset = 1'b1;
    startPC = 64'h0c;
    m_reset(64'h0c);
    #1;
    check("async_reset_pc", currentPC, 64'h0c);
    check("async_reset_dout", dMemOut, 64'h0);
    @(negedge Clk);
    Reset = 1'b0;
    tick(1'b0);
    check("after_release_pc", currentPC, 64'h10);

    apply_reset(64'h40, 0, 1'b0);
    for (int e = 1; e <= 8; e++) begin
      tick(1'b0);
      check("nop_pc", currentPC, 64'h40 + 64'(4 * e));
      check("nop_dout", dMemOut, 64'h0);
    end

    apply_reset(64'h0, 0, 1'b0);
    for (int r = 0; r < 1500; r++) begin
      if ($urandom_range(0, 99) < 6) begin
        case ($urandom_range(0, 3))
          0:       s = {$urandom, $urandom};
          1:       s = {$urandom, 24'h0, 6'($urandom_range(0, 63)), 2'b00};
          default: s = {56'h0, 6'($urandom_range(0, 15)), 2'b00};
        endcase
        apply_reset(s, $urandom_range(0, 2), 1'b1);
      end else begin
        tick(1'b1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
